// File: rtl/wb_buf_pkg.sv
// ============================================================================
// Module   : wb_buf_pkg
// Brief    : Shared defaults and FSM state type for the writeback buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_buf_pkg;

    localparam int c_def_addr_w = 32;
    localparam int c_def_data_w = 32;
    localparam int c_def_depth  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_buf_match.sv
// ============================================================================
// Module   : wb_buf_match
// Brief    : Per-entry address compare with valid mask; reports the youngest
//            matching entry, where age is measured from the FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_buf_match
    import wb_buf_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int DEPTH  = c_def_depth
) (
    input  logic [ADDR_W-1:0]             i_adr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  i_entry_adr,
    input  logic [DEPTH-1:0]              i_valid,
    input  logic [$clog2(DEPTH)-1:0]      i_head,
    output logic                          o_hit,
    output logic [$clog2(DEPTH)-1:0]      o_idx
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [DEPTH-1:0] w_match;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_cmp
            assign w_match[g] = i_valid[g] && (i_entry_adr[g] == i_adr);
        end
    endgenerate

    // Walk from the head towards the tail so the last match seen is the youngest.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[i_head + c_ptr_w'(k)]) begin
                o_hit = 1'b1;
                o_idx = i_head + c_ptr_w'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_buffer.sv
// ============================================================================
// Module   : writeback_buffer
// Brief    : Coalescing FIFO of evicted lines drained to memory over a
//            single-beat bus. Define WB_BUF_FORWARD_EN to enable lookup
//            forwarding of buffered data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_buffer
    import wb_buf_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = c_def_data_w,
    parameter int DEPTH  = c_def_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDR_W-1:0]          push_adr_i,
    input  logic [DATA_W-1:0]          push_dat_i,
    input  logic [ADDR_W-1:0]          lookup_adr_i,
    output logic                       lookup_hit_o,
    output logic [DATA_W-1:0]          lookup_dat_o,
    output logic                       cyc_o,
    output logic                       stb_o,
    output logic                       we_o,
    output logic [ADDR_W-1:0]          adr_o,
    output logic [DATA_W-1:0]          dat_o,
    input  logic                       ack_i,
    input  logic                       err_i,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] r_adr;
    logic [DEPTH-1:0][DATA_W-1:0] r_dat;
    logic [DEPTH-1:0]             r_valid;
    logic [c_ptr_w-1:0]           r_head;
    logic [c_ptr_w-1:0]           r_tail;
    logic [c_cnt_w-1:0]           r_count;
    logic                         r_err;
    wb_state_t                    r_state;
    wb_state_t                    w_state_nxt;

    logic                         w_full;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_append;
    logic [DEPTH-1:0]             w_coal_mask;
    logic                         w_coal_hit;
    logic [c_ptr_w-1:0]           w_coal_idx;

    assign w_full       = (r_count == c_cnt_w'(DEPTH));
    assign push_ready_o = !w_full;
    assign full_o       = w_full;
    assign empty_o      = (r_count == '0);
    assign count_o      = r_count;
    assign err_o        = r_err;
    assign w_push       = push_valid_i && !w_full;
    assign w_append     = w_push && !w_coal_hit;

    // The head being written to memory must never change, so hide it from coalescing.
    always_comb begin
        w_coal_mask = r_valid;
        if (r_state == ST_BUS) begin
            w_coal_mask[r_head] = 1'b0;
        end
    end

    wb_buf_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_coal_match (
        .i_adr       (push_adr_i),
        .i_entry_adr (r_adr),
        .i_valid     (w_coal_mask),
        .i_head      (r_head),
        .o_hit       (w_coal_hit),
        .o_idx       (w_coal_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        cyc_o       = 1'b0;
        stb_o       = 1'b0;
        we_o        = 1'b0;
        adr_o       = '0;
        dat_o       = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = r_adr[r_head];
                dat_o = r_dat[r_head];
                if (ack_i || err_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr   <= '0;
            r_dat   <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push && w_coal_hit) begin
                r_dat[w_coal_idx] <= push_dat_i;
            end else if (w_push) begin
                r_adr[r_tail]   <= push_adr_i;
                r_dat[r_tail]   <= push_dat_i;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                if (err_i) begin
                    r_err <= 1'b1;
                end
            end
            r_count <= r_count + c_cnt_w'(w_append) - c_cnt_w'(w_pop);
        end
    end

`ifdef WB_BUF_FORWARD_EN
    logic               w_fwd_hit;
    logic [c_ptr_w-1:0] w_fwd_idx;

    wb_buf_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd_match (
        .i_adr       (lookup_adr_i),
        .i_entry_adr (r_adr),
        .i_valid     (r_valid),
        .i_head      (r_head),
        .o_hit       (w_fwd_hit),
        .o_idx       (w_fwd_idx)
    );

    assign lookup_hit_o = w_fwd_hit;
    assign lookup_dat_o = w_fwd_hit ? r_dat[w_fwd_idx] : '0;
`else
    logic w_unused_lookup;

    assign w_unused_lookup = ^lookup_adr_i;
    assign lookup_hit_o    = 1'b0;
    assign lookup_dat_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_buffer.sv
// ============================================================================
// Module   : tb_writeback_buffer
// Brief    : Directed self-checking bench for writeback_buffer with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] push_adr_i = '0;
    logic [31:0] push_dat_i = '0;
    logic [31:0] lookup_adr_i = '0;
    logic        lookup_hit_o;
    logic [31:0] lookup_dat_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        empty_o, full_o;
    logic [2:0]  count_o;
    logic        err_o;

    writeback_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_adr_i   (push_adr_i),
        .push_dat_i   (push_dat_i),
        .lookup_adr_i (lookup_adr_i),
        .lookup_hit_o (lookup_hit_o),
        .lookup_dat_o (lookup_dat_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        push_valid_i = 1'b1;
        push_adr_i   = a;
        push_dat_i   = d;
    endtask

    // Reference model: an ordered list of pending lines plus a "write in flight" flag.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } ent_t;

    ent_t m_q[$];
    bit   m_bus = 1'b0;
    bit   m_err = 1'b0;
    bit   m_pop, m_push, m_nbus;
    int   m_tgt;
    ent_t m_e;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_bus = 1'b0;
            m_err = 1'b0;
        end else begin
            m_pop  = m_bus && (ack_i || err_i);
            m_push = push_valid_i && (m_q.size() < 4);
            m_nbus = m_bus ? !(ack_i || err_i) : (m_q.size() != 0);
            m_tgt  = -1;
            if (m_push) begin
                for (int i = m_q.size() - 1; i >= (m_bus ? 1 : 0); i--) begin
                    if (m_tgt < 0 && m_q[i].adr == push_adr_i) m_tgt = i;
                end
                if (m_tgt >= 0) begin
                    m_e = m_q[m_tgt];
                    m_e.dat = push_dat_i;
                    m_q[m_tgt] = m_e;
                end else begin
                    m_e.adr = push_adr_i;
                    m_e.dat = push_dat_i;
                    m_q.push_back(m_e);
                end
            end
            if (m_pop) begin
                void'(m_q.pop_front());
                if (err_i) m_err = 1'b1;
            end
            m_bus = m_nbus;
        end
    end

    logic [31:0] e_adr, e_dat, e_ldat;
    logic        e_hit;

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            e_adr  = m_bus ? m_q[0].adr : 32'h0;
            e_dat  = m_bus ? m_q[0].dat : 32'h0;
            e_hit  = 1'b0;
            e_ldat = 32'h0;
`ifdef WB_BUF_FORWARD_EN
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].adr == lookup_adr_i) begin
                    e_hit  = 1'b1;
                    e_ldat = m_q[i].dat;
                end
            end
`endif
            chk("count", count_o, m_q.size());
            chk("empty", empty_o, m_q.size() == 0);
            chk("full", full_o, m_q.size() == 4);
            chk("ready", push_ready_o, m_q.size() != 4);
            chk("cyc", cyc_o, m_bus);
            chk("stb", stb_o, m_bus);
            chk("we", we_o, m_bus);
            chk("adr", adr_o, e_adr);
            chk("dat", dat_o, e_dat);
            chk("err", err_o, m_err);
            chk("lk_hit", lookup_hit_o, e_hit);
            chk("lk_dat", lookup_dat_o, e_ldat);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick();
        check_en = 1'b1;
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_lkhit", lookup_hit_o, 0);
        rst = 1'b0;

        // Single write: issue latency and completion
        lookup_adr_i = 32'h100;
        push(32'h100, 32'hAAAA);
        tick();
        push_valid_i = 1'b0;
        chk("t1_cyc_e0", cyc_o, 0);
        tick();
        chk("t1_cyc_e1", cyc_o, 1);
        chk("t1_adr", adr_o, 32'h100);
        chk("t1_dat", dat_o, 32'hAAAA);
        tick();
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t1_empty", empty_o, 1);
        chk("t1_cyc_done", cyc_o, 0);

        // Coalesce into a waiting entry
        push(32'h100, 32'h1);
        tick();
        push(32'h200, 32'h2);
        tick();
        push(32'h200, 32'h3);
        tick();
        push_valid_i = 1'b0;
        chk("t2_count", count_o, 2);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        chk("t2_adr2", adr_o, 32'h200);
        chk("t2_dat2", dat_o, 32'h3);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t2_empty", empty_o, 1);

        // Push matching the in-flight head appends
        push(32'h100, 32'h1);
        tick();
        push_valid_i = 1'b0;
        tick();
        chk("t3_cyc", cyc_o, 1);
        push(32'h100, 32'h5);
        tick();
        push_valid_i = 1'b0;
        chk("t3_count", count_o, 2);
        chk("t3_adr", adr_o, 32'h100);
        chk("t3_dat", dat_o, 32'h1);
`ifdef WB_BUF_FORWARD_EN
        chk("t3_lkhit", lookup_hit_o, 1);
        chk("t3_lkdat", lookup_dat_o, 32'h5);
`endif
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        chk("t3_dat2", dat_o, 32'h5);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t3_empty", empty_o, 1);

        // Coalesce into head while still idle
        push(32'h300, 32'h7);
        tick();
        push(32'h300, 32'h8);
        tick();
        push_valid_i = 1'b0;
        chk("t4_count", count_o, 1);
        chk("t4_cyc", cyc_o, 1);
        chk("t4_dat", dat_o, 32'h8);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t4_empty", empty_o, 1);

        // Full buffer: no push while full even with a same-cycle pop
        push(32'h10, 32'h11);
        tick();
        push(32'h20, 32'h22);
        tick();
        push(32'h30, 32'h33);
        tick();
        push(32'h40, 32'h44);
        tick();
        chk("t5_full", full_o, 1);
        chk("t5_ready", push_ready_o, 0);
        push(32'h50, 32'h55);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t5_count3", count_o, 3);
        chk("t5_ready3", push_ready_o, 1);
        tick();
        push_valid_i = 1'b0;
        chk("t5_count4", count_o, 4);
        for (int k = 0; k < 40 && count_o != 0; k++) begin
            ack_i = cyc_o;
            tick();
        end
        ack_i = 1'b0;
        chk("t5_drained", empty_o, 1);

        // Bus error drops the entry and sets the sticky flag
        push(32'hA00, 32'h1);
        tick();
        push(32'hB00, 32'h2);
        tick();
        push_valid_i = 1'b0;
        err_i = 1'b1;
        tick();
        err_i = 1'b0;
        chk("t6_err", err_o, 1);
        chk("t6_count", count_o, 1);
        tick();
        chk("t6_adr", adr_o, 32'hB00);
        ack_i = 1'b1;
        err_i = 1'b1;
        tick();
        ack_i = 1'b0;
        err_i = 1'b0;
        chk("t6_count0", count_o, 0);

        // ack outside BUS ignored, then reset mid-transaction
        push(32'hC00, 32'hC);
        tick();
        push_valid_i = 1'b0;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t7_ign_count", count_o, 1);
        chk("t7_ign_cyc", cyc_o, 1);
        push(32'hD00, 32'hD);
        tick();
        push(32'hE00, 32'hE);
        tick();
        push_valid_i = 1'b0;
        chk("t7_count3", count_o, 3);
        chk("t7_err_sticky", err_o, 1);
        rst = 1'b1;
        tick();
        chk("t7_rst_cyc", cyc_o, 0);
        chk("t7_rst_count", count_o, 0);
        chk("t7_rst_err", err_o, 0);
        rst = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; DEPTH, default 4, entry count (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 push_valid_i  input  1  controller offers an evicted line.
REQ-005 push_ready_o  output  1  buffer can accept; equals !full_o.
REQ-006 push_adr_i  input  ADDR_W  evicted line address.
REQ-007 push_dat_i  input  DATA_W  evicted line data.
REQ-008 lookup_adr_i  input  ADDR_W  controller miss address for forwarding check.
REQ-009 lookup_hit_o  output  1  lookup_adr_i matches a valid entry (combinational).
REQ-010 lookup_dat_o  output  DATA_W  data of youngest matching entry; 0 when no hit.
REQ-011 cyc_o, stb_o, we_o  output  1 each  memory bus cycle, strobe, write enable.
REQ-012 adr_o  output  ADDR_W; dat_o  output  DATA_W  head entry driven to memory.
REQ-013 ack_i, err_i  input  1 each  memory completion / error.
REQ-014 empty_o, full_o  output  1 each; count_o  output  $clog2(DEPTH)+1  occupancy.
REQ-015 err_o  output  1  sticky bus-error flag.

Function
REQ-016 Push SHALL be accepted on an edge where push_valid_i && push_ready_o; no push while full, even if a pop occurs the same cycle.
REQ-017 Accepted push whose address equals a valid non-head entry (or head while FSM IDLE) SHALL overwrite that entry's data in place, count unchanged (coalesce).
REQ-018 Push matching only the in-flight head (FSM BUS) SHALL append a new entry; in-flight head data SHALL never change.
REQ-019 FSM states: IDLE, BUS. IDLE->BUS when count_o!=0; BUS->IDLE on ack_i or err_i.
REQ-020 In BUS: cyc_o=stb_o=we_o=1, adr_o/dat_o = head entry, stable until ack_i/err_i; in IDLE all bus outputs 0.
REQ-021 Latency: push accepted at edge E0 into empty buffer -> cyc_o high from edge E1.
REQ-022 On ack_i in BUS the head SHALL pop at that edge; next entry issues from following edge (one IDLE cycle between writes).
REQ-023 On err_i in BUS the head SHALL pop (discarded) and err_o SHALL set; err_o clears only on reset; ack_i and err_i together treated as err_i.
REQ-024 Simultaneous push and pop: count unchanged, ordering FIFO.
REQ-025 ack_i/err_i outside BUS SHALL be ignored.
REQ-026 Pointers SHALL wrap modulo DEPTH; count_o ranges 0..DEPTH.

Reset
REQ-027 On rst: all entries invalid, pointers 0, count_o=0, empty_o=1, full_o=0, FSM IDLE, cyc_o/stb_o/we_o=0, adr_o/dat_o=0, err_o=0, lookup_hit_o=0.
REQ-028 Reset during BUS SHALL abandon the transaction; cyc_o low from the reset edge; pending entries discarded.

Configuration
REQ-029 Macro WB_BUF_FORWARD_EN defined: lookup compare active across all valid entries including in-flight head, youngest match wins.
REQ-030 Macro WB_BUF_FORWARD_EN undefined: lookup_hit_o=0, lookup_dat_o=0, no compare logic; ports retained.

Structure
REQ-031 Package wb_buf_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the FSM state enum.
REQ-032 Address-match logic SHALL be one sub-module wb_buf_match (per-entry compare, valid mask, youngest-hit priority), shared by coalesce and forwarding.

Verification
REQ-033 Push 0x100/0xAAAA into empty -> cyc_o high next edge, adr_o=0x100, dat_o=0xAAAA; ack_i after 3 cycles -> empty_o=1.
REQ-034 Push 0x100/0x1, hold ack_i low, push 0x200/0x2 then 0x200/0x3 -> count_o=2, second write dat_o=0x3.
REQ-035 With head 0x100/0x1 in BUS, push 0x100/0x5 -> count_o=2, adr_o/dat_o stay 0x100/0x1; lookup 0x100 -> hit, dat 0x5 (FORWARD_EN).
REQ-036 Fill 4 entries, push_valid_i held with ack_i same cycle -> no push accepted, count_o=3 after edge, push accepted next cycle.
REQ-037 err_i on first write -> err_o=1, entry dropped, next entry issued; rst -> err_o=0.
REQ-038 rst asserted mid-BUS with 3 entries -> cyc_o=0, count_o=0 after the reset edge.
